// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions.
// Contents: word type, scheduler FSM state enum, round constants K, initial hash
// values IV, and the sigma / big-sigma / ch / maj helper functions used by the
// message scheduler and the round datapath.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRound,
    StFinal,
    StDone
  } sha_state_e;

  localparam word_t K_TABLE [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV_TABLE [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Small sigma functions used by the message expansion.
  function automatic word_t sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Round-function helpers for the datapath.
  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_wsched.sv
// SHA-256 message schedule: 16-word circular buffer plus W[t] expansion.
// Ports:
//   clk_i        clock
//   wr_en_i      load-port write strobe (message word from the register bank)
//   wr_idx_i     load-port word index 0..15
//   wr_data_i    load-port data
//   round_en_i   a round is in progress this cycle
//   t_i          current round index
//   w_o          W[t] for the current round
// Buffer contents are not reset; software reloads all 16 words per block.
module sha256_wsched
  import sha256_pkg::*;
(
  input  logic       clk_i,
  input  logic       wr_en_i,
  input  logic [3:0] wr_idx_i,
  input  word_t      wr_data_i,
  input  logic       round_en_i,
  input  logic [5:0] t_i,
  output word_t      w_o
);

  word_t mem_q [16];
  word_t mem_d [16];

  logic  [3:0] idx_t;
  logic  [3:0] idx_m2;
  logic  [3:0] idx_m7;
  logic  [3:0] idx_m15;
  logic        expand;
  word_t       w_new;

  // 4-bit index arithmetic wraps naturally, giving the mod-16 buffer slots.
  assign idx_t   = t_i[3:0];
  assign idx_m2  = t_i[3:0] - 4'd2;
  assign idx_m7  = t_i[3:0] - 4'd7;
  assign idx_m15 = t_i[3:0] - 4'd15;
  assign expand  = (t_i[5:4] != 2'b00);

  assign w_new = sigma1(mem_q[idx_m2]) + mem_q[idx_m7] + sigma0(mem_q[idx_m15]) + mem_q[idx_t];
  assign w_o   = expand ? w_new : mem_q[idx_t];

  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      mem_d[wr_idx_i] = wr_data_i;
    end else if (round_en_i && expand) begin
      // Slot t%16 held W[t-16], which is no longer needed after this round.
      mem_d[idx_t] = w_new;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sha256_sched_ctrl.sv
// SHA-256 block sequencer and message scheduler.
// Walks the compression datapath through IV load / init, N_ROUNDS rounds and the
// final add, supplying W[t] and K[t] every round.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   blk_wr_i, blk_idx_i, blk_data_i   message word load (accepted when not busy)
//   start_i, first_i                  start a block; first_i selects IV load
//   abort_i                           abandon the current block
//   busy_o, done_o, ovr_o             status: busy, done pulse, sticky overrun
//   dp_iv_o, dp_init_o, dp_round_o,
//   dp_final_o                        datapath phase strobes
//   dp_t_o, dp_w_o, dp_k_o            round index, W[t], K[t]
module sha256_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned N_ROUNDS = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        blk_wr_i,
  input  logic [3:0]  blk_idx_i,
  input  logic [31:0] blk_data_i,
  input  logic        start_i,
  input  logic        first_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovr_o,
  output logic        dp_iv_o,
  output logic        dp_init_o,
  output logic        dp_round_o,
  output logic [5:0]  dp_t_o,
  output logic [31:0] dp_w_o,
  output logic [31:0] dp_k_o,
  output logic        dp_final_o
);

  localparam logic [5:0] LastT = 6'(N_ROUNDS - 1);

  sha_state_e state_q, state_d;
  logic [5:0] t_q, t_d;
  logic       first_q, first_d;
  logic       ovr_q, ovr_d;

  logic       idle_like;
  logic       busy;
  logic       start_acc;
  logic       in_round;
  word_t      w_sched;

  // DONE behaves as IDLE for starts and writes so blocks can run back to back.
  assign idle_like = (state_q == StIdle) || (state_q == StDone);
  assign busy      = (state_q == StInit) || (state_q == StRound) || (state_q == StFinal);
  assign start_acc = idle_like && start_i && !abort_i;
  assign in_round  = (state_q == StRound);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    first_d = first_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_acc) begin
          state_d = StInit;
          first_d = first_i;
          ovr_d   = 1'b0;
          t_d     = '0;
        end
      end
      StInit: begin
        state_d = StRound;
        t_d     = '0;
      end
      StRound: begin
        if (t_q == LastT) begin
          state_d = StFinal;
          t_d     = '0;
        end else begin
          t_d = t_q + 6'd1;
        end
      end
      StFinal: state_d = StDone;
      default: state_d = StIdle;
    endcase

    if (busy) begin
      // A start that loses to abort is not an overrun; a write is always dropped.
      if (blk_wr_i || (start_i && !abort_i)) begin
        ovr_d = 1'b1;
      end
      if (abort_i) begin
        state_d = StIdle;
        t_d     = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      t_q     <= '0;
      first_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      first_q <= first_d;
      ovr_q   <= ovr_d;
    end
  end

  sha256_wsched u_wsched (
    .clk_i      (clk_i),
    .wr_en_i    (blk_wr_i && idle_like),
    .wr_idx_i   (blk_idx_i),
    .wr_data_i  (blk_data_i),
    .round_en_i (in_round),
    .t_i        (t_q),
    .w_o        (w_sched)
  );

  // All outputs are decoded from registered state only.
  assign busy_o     = busy;
  assign done_o     = (state_q == StDone);
  assign ovr_o      = ovr_q;
  assign dp_init_o  = (state_q == StInit);
  assign dp_iv_o    = (state_q == StInit) && first_q;
  assign dp_round_o = in_round;
  assign dp_final_o = (state_q == StFinal);
  assign dp_t_o     = in_round ? t_q : 6'd0;
  assign dp_w_o     = in_round ? w_sched : 32'd0;
  assign dp_k_o     = in_round ? K_TABLE[t_q] : 32'd0;

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Directed bench for sha256_sched_ctrl with a W[t] scoreboard.
module tb_sha256_sched_ctrl;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        blk_wr_i = 1'b0;
  logic [3:0]  blk_idx_i = '0;
  logic [31:0] blk_data_i = '0;
  logic        start_i = 1'b0;
  logic        first_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, ovr_o, dp_iv_o, dp_init_o, dp_round_o, dp_final_o;
  logic [5:0]  dp_t_o;
  logic [31:0] dp_w_o, dp_k_o;

  always #5 clk = ~clk;

  sha256_sched_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .blk_wr_i   (blk_wr_i),
    .blk_idx_i  (blk_idx_i),
    .blk_data_i (blk_data_i),
    .start_i    (start_i),
    .first_i    (first_i),
    .abort_i    (abort_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .ovr_o      (ovr_o),
    .dp_iv_o    (dp_iv_o),
    .dp_init_o  (dp_init_o),
    .dp_round_o (dp_round_o),
    .dp_t_o     (dp_t_o),
    .dp_w_o     (dp_w_o),
    .dp_k_o     (dp_k_o),
    .dp_final_o (dp_final_o)
  );

  typedef struct packed {
    logic [5:0]  t;
    logic [31:0] w;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] msg [16];
  logic [31:0] wexp [64];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          final_cnt = 0;
  int          final_cyc = -1;
  int          done_cnt = 0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Known round constants at a few spot positions.
  function automatic bit k_ref(input logic [5:0] t, output logic [31:0] k);
    k = '0;
    case (t)
      6'd0:  begin k = 32'h428a2f98; return 1'b1; end
      6'd1:  begin k = 32'h71374491; return 1'b1; end
      6'd16: begin k = 32'he49b69c1; return 1'b1; end
      6'd17: begin k = 32'hefbe4786; return 1'b1; end
      6'd32: begin k = 32'h27b70a85; return 1'b1; end
      6'd63: begin k = 32'hc67178f2; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic build_sched();
    sb.delete();
    for (int t = 0; t < 16; t++) wexp[t] = msg[t];
    for (int t = 16; t < 64; t++)
      wexp[t] = s1(wexp[t-2]) + wexp[t-7] + s0(wexp[t-15]) + wexp[t-16];
    for (int t = 0; t < N; t++) sb.push_back('{t: 6'(t), w: wexp[t]});
  endtask

  task automatic cycle();
    exp_t        e;
    logic [31:0] kv;
    @(posedge clk);
    #1;
    cyc++;
    chk("strobe_excl", 32'(($countones({dp_init_o, dp_round_o, dp_final_o}) <= 1) &&
                           (!dp_iv_o || dp_init_o)), 32'd1);
    if (dp_round_o) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("round_t", 32'(dp_t_o), 32'(e.t));
        chk("round_w", dp_w_o, e.w);
        if (k_ref(dp_t_o, kv)) chk("round_k", dp_k_o, kv);
      end
    end
    if (dp_final_o) begin
      final_cnt++;
      final_cyc = cyc;
    end
    if (done_o) done_cnt++;
  endtask

  task automatic load();
    for (int i = 0; i < 16; i++) begin
      blk_wr_i = 1'b1; blk_idx_i = 4'(i); blk_data_i = msg[i];
      cycle();
    end
    blk_wr_i = 1'b0;
  endtask

  task automatic start_block(input logic first, input logic wr, input logic [3:0] idx,
                             input logic [31:0] data);
    if (wr) msg[idx] = data;
    build_sched();
    start_i = 1'b1; first_i = first;
    blk_wr_i = wr; blk_idx_i = idx; blk_data_i = data;
    cyc = 0; final_cnt = 0; final_cyc = -1; done_cnt = 0;
    cycle();
    start_i = 1'b0; first_i = 1'b0; blk_wr_i = 1'b0;
    chk("init_strobe", 32'(dp_init_o), 32'd1);
    chk("init_iv", 32'(dp_iv_o), 32'(first));
    chk("init_busy", 32'(busy_o), 32'd1);
  endtask

  task automatic run_to_done();
    int n = 0;
    while (!done_o && n < 200) begin
      cycle();
      n++;
    end
    chk("done_seen", 32'(done_o), 32'd1);
    chk("done_cycle", 32'(cyc), 32'(N + 3));
    chk("final_cycle", 32'(final_cyc), 32'(N + 2));
    chk("final_cnt", 32'(final_cnt), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("done_busy", 32'(busy_o), 32'd0);
  endtask

  task automatic wait_round(input int t);
    int n = 0;
    while (!(dp_round_o && dp_t_o == 6'(t)) && n < 200) begin
      cycle();
      n++;
    end
    chk("reach_round", 32'(dp_round_o && dp_t_o == 6'(t)), 32'd1);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  initial begin
    // Reset state
    repeat (2) cycle();
    rst_i = 1'b0;
    cycle();
    chk("rst_ctl", 32'({busy_o, done_o, ovr_o, dp_iv_o, dp_init_o, dp_round_o, dp_final_o}), 32'd0);
    chk("rst_t", 32'(dp_t_o), 32'd0);
    chk("rst_w", dp_w_o, 32'd0);
    chk("rst_k", dp_k_o, 32'd0);

    // "abc" block with IV load; spot-check the known schedule words.
    set_abc();
    load();
    start_block(1'b1, 1'b0, 4'd0, 32'd0);
    chk("abc_w16", wexp[16], 32'h61626380);
    chk("abc_w17", wexp[17], 32'h000f0000);
    run_to_done();
    cycle();
    chk("done_pulse_len", 32'(done_o), 32'd0);

    // Back-to-back: second block starts in the DONE cycle, buffer holds W[48..63].
    set_abc();
    load();
    start_block(1'b1, 1'b0, 4'd0, 32'd0);
    run_to_done();
    for (int i = 0; i < 16; i++) msg[i] = wexp[48 + i];
    start_block(1'b0, 1'b0, 4'd0, 32'd0);
    run_to_done();

    // Overrun: write at round 5 and start at round 20 are both dropped.
    cycle();
    set_abc();
    load();
    start_block(1'b1, 1'b0, 4'd0, 32'd0);
    wait_round(5);
    blk_wr_i = 1'b1; blk_idx_i = 4'd3; blk_data_i = 32'hffffffff;
    cycle();
    blk_wr_i = 1'b0;
    chk("ovr_after_wr", 32'(ovr_o), 32'd1);
    wait_round(20);
    start_i = 1'b1; first_i = 1'b1;
    cycle();
    start_i = 1'b0; first_i = 1'b0;
    chk("busy_start_ignored", 32'({busy_o, dp_t_o}), 32'({1'b1, 6'd21}));
    run_to_done();
    chk("ovr_at_done", 32'(ovr_o), 32'd1);
    cycle();
    chk("ovr_idle_held", 32'(ovr_o), 32'd1);

    // Next start clears ovr; abort (with a competing start) at t=30.
    for (int i = 0; i < 16; i++) msg[i] = 32'h01010101 * 32'(i + 1);
    load();
    start_block(1'b1, 1'b0, 4'd0, 32'd0);
    chk("ovr_cleared", 32'(ovr_o), 32'd0);
    wait_round(30);
    abort_i = 1'b1; start_i = 1'b1;
    cycle();
    abort_i = 1'b0; start_i = 1'b0;
    chk("abort_busy", 32'({busy_o, dp_round_o, dp_init_o}), 32'd0);
    chk("abort_no_ovr", 32'(ovr_o), 32'd0);
    sb.delete();
    repeat (80) cycle();
    chk("abort_no_final", 32'(final_cnt), 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < 16; i++) msg[i] = 32'h9e3779b9 ^ (32'(i) << 4);
    load();
    start_block(1'b0, 1'b0, 4'd0, 32'd0);
    run_to_done();

    // Reset at t=40, then a fresh abc block reproduces the same trace.
    set_abc();
    load();
    start_block(1'b1, 1'b0, 4'd0, 32'd0);
    wait_round(40);
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    sb.delete();
    chk("midrst_ctl", 32'({busy_o, done_o, ovr_o, dp_iv_o, dp_init_o, dp_round_o, dp_final_o}), 32'd0);
    chk("midrst_twk", 32'(dp_t_o) | dp_w_o | dp_k_o, 32'd0);
    set_abc();
    load();
    start_block(1'b1, 1'b0, 4'd0, 32'd0);
    run_to_done();

    // Same-cycle write and start: write lands in round 0.
    set_abc();
    load();
    start_block(1'b1, 1'b1, 4'd0, 32'hdeadbeef);
    cycle();
    chk("same_cycle_w0", dp_w_o, 32'hdeadbeef);
    run_to_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
